pipo_load_arbiter: RTL and testbench

//  Shares one parallel-in/parallel-out register between N_REQ requesters.
//  Per-requester valid/ready handshake; round-robin grant; drives the

---
 rtl/pipo_ctrl_pkg.sv | 26 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/pipo_load_arbiter.sv | 121 ++++++++++++
 tb/tb_pipo_load_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipo_ctrl_pkg.sv
// ============================================================================
// pipo_ctrl_pkg : shared types and width helpers for the PIPO load arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package pipo_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Index width for N requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold 0..h.
  function automatic int cnt_w(input int h);
    return (h <= 1) ? 1 : $clog2(h + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, first set request at or after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = pipo_ctrl_pkg::id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx,
  output logic [N_REQ-1:0] onehot
);

  localparam logic [ID_W:0] NQ = (ID_W + 1)'(N_REQ);

  logic [ID_W:0] cand;

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr + k stays below 2*N_REQ, so one conditional subtract is a full modulo.
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= NQ) begin
        cand = cand - NQ;
      end
      if (!any && req[cand[ID_W-1:0]]) begin
        any                     = 1'b1;
        idx                     = cand[ID_W-1:0];
        onehot[cand[ID_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipo_load_arbiter.sv
// ============================================================================
// pipo_load_arbiter : round-robin loader for a shared PIPO register with a
//                     post-load hold window
// Rev 1.0
// ============================================================================
`default_nettype none

module pipo_load_arbiter
  import pipo_ctrl_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*WIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [WIDTH-1:0]          pipo_data,
  output logic                      pipo_upd,
  output logic [id_w(N_REQ)-1:0]    gnt_id,
  output logic                      busy
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = cnt_w(HOLD_CYCLES);

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]   pipo_data_q, pipo_data_d;
  logic               pipo_upd_q, pipo_upd_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;

  logic               pick_any;
  logic [ID_W-1:0]    pick_idx;
  logic [N_REQ-1:0]   pick_onehot;
  logic [WIDTH-1:0]   req_word [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign req_word[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    pipo_data_d = pipo_data_q;
    gnt_id_d    = gnt_id_q;
    pipo_upd_d  = 1'b0;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        // Only the winner sees ready, so valid&ready never hits two requesters.
        req_ready = pick_onehot;
        if (pick_any) begin
          pipo_data_d = req_word[pick_idx];
          gnt_id_d    = pick_idx;
          ptr_d       = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
          hold_cnt_d  = HOLD_LOAD;
          pipo_upd_d  = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      pipo_data_q <= '0;
      pipo_upd_q  <= 1'b0;
      gnt_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      pipo_data_q <= pipo_data_d;
      pipo_upd_q  <= pipo_upd_d;
      gnt_id_q    <= gnt_id_d;
    end
  end

  assign pipo_data = pipo_data_q;
  assign pipo_upd  = pipo_upd_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = (state_q == HOLD) && !rst;

endmodule

`default_nettype wire

// File: tb/tb_pipo_load_arbiter.sv
// ============================================================================
// tb_pipo_load_arbiter : directed stimulus with a queue-based scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipo_load_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  pipo_data;
  logic        pipo_upd;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [3:0]  pipo_reg;

  int n_cmp = 0;
  int n_err = 0;

  // Expected loads: {data[5:2], id[1:0]}
  logic [5:0] exp_q [$];

  pipo_load_arbiter #(
    .WIDTH       (4),
    .N_REQ       (4),
    .HOLD_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pipo_data (pipo_data),
    .pipo_upd  (pipo_upd),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The shared register downstream, reset on the same rst.
  always @(posedge clk or posedge rst) begin
    if (rst) pipo_reg <= 4'h0;
    else     pipo_reg <= pipo_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_load(input logic [3:0] d, input logic [1:0] id);
    exp_q.push_back({d, id});
  endtask

  // Monitor: every update pulse must match the next queued load.
  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst && pipo_upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_upd", 32'(gnt_id), 32'hFF);
      end else begin
        e = exp_q.pop_front();
        check("upd_data", 32'(pipo_data), 32'(e[5:2]));
        check("upd_gnt",  32'(gnt_id),    32'(e[1:0]));
        check("upd_busy", 32'(busy),      32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with every requester valid
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 16'h4321;
    cyc();
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_data",  32'(pipo_data), 32'h0);
    check("rst_upd",   32'(pipo_upd),  32'h0);
    check("rst_gnt",   32'(gnt_id),    32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    cyc();
    rst       = 1'b0;
    req_valid = 4'h0;
    cyc();

    // 2: single request from 2
    req_valid = 4'b0100;
    req_data  = 16'h0A00;
    #1;
    check("t2_ready", 32'(req_ready), 32'b0100);
    expect_load(4'hA, 2'd2);
    cyc();
    req_valid = 4'h0;
    #1;
    check("t2_busy1", 32'(busy), 32'd1);
    cyc();
    #1;
    check("t2_busy2", 32'(busy), 32'd1);
    check("t2_reg",   32'(pipo_reg), 32'hA);
    cyc();
    #1;
    check("t2_busy3", 32'(busy), 32'd0);

    // 3: fairness from ptr=0 with all requesters busy
    rst = 1'b1;
    cyc();
    rst       = 1'b0;
    req_valid = 4'hF;
    req_data  = 16'h4321;
    #1;
    check("t3_ready0", 32'(req_ready), 32'b0001);
    expect_load(4'h1, 2'd0);
    expect_load(4'h2, 2'd1);
    expect_load(4'h3, 2'd2);
    expect_load(4'h4, 2'd3);
    expect_load(4'h1, 2'd0);
    cyc();
    #1;
    check("t3_hold_ready", 32'(req_ready), 32'h0);
    repeat (12) cyc();
    req_valid = 4'h0;
    repeat (2) cyc();

    // 4: wrap; after granting 2 the pointer sits at 3
    req_valid = 4'b0100;
    req_data  = 16'h0500;
    #1;
    check("t4_ready2", 32'(req_ready), 32'b0100);
    expect_load(4'h5, 2'd2);
    cyc();
    req_valid = 4'h0;
    repeat (2) cyc();
    req_valid = 4'b1001;
    req_data  = 16'h9006;
    #1;
    check("t4_ready3", 32'(req_ready), 32'b1000);
    expect_load(4'h9, 2'd3);
    expect_load(4'h6, 2'd0);
    cyc();
    req_valid = 4'b0001;
    repeat (2) cyc();
    #1;
    check("t4_ready0", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'h0;
    repeat (2) cyc();

    // Pointer should now be 1: reqs 0 and 1 -> 1 wins
    req_valid = 4'b0011;
    req_data  = 16'h0073;
    #1;
    check("t4_ptr1", 32'(req_ready), 32'b0010);
    expect_load(4'h7, 2'd1);
    cyc();

    // 5: reset in HOLD cycle 1, after the monitor has seen the pulse
    #2;
    rst = 1'b1;
    req_valid = 4'b0011;
    req_data  = 16'h00C3;
    #1;
    check("t5_busy",  32'(busy),      32'd0);
    check("t5_data",  32'(pipo_data), 32'h0);
    check("t5_ready", 32'(req_ready), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("t5_ready0", 32'(req_ready), 32'b0001);
    expect_load(4'h3, 2'd0);
    cyc();

    // 6: req 1 withdraws during HOLD, req 3 arrives
    req_valid = 4'b0010;
    cyc();
    req_valid = 4'b1000;
    req_data  = 16'hD0C3;
    cyc();
    #1;
    check("t6_ready3", 32'(req_ready), 32'b1000);
    expect_load(4'hD, 2'd3);
    cyc();
    req_valid = 4'h0;
    repeat (4) cyc();
    #1;
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
